// File: rtl/four_bit_adder.sv
// Registered unsigned ripple-carry adder with a one-cycle valid pipeline.
// Define FOUR_BIT_ADDER_SUB_EN to add a sub input (a + ~b + 1 when sub=1).
module four_bit_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef FOUR_BIT_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic             in_valid,
   output logic [WIDTH:0]   s,
   output logic             out_valid
);

   // One full-adder cell: returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic ai, input logic bi, input logic ci);
      logic sum_bit;
      logic carry_bit;
      sum_bit   = ai ^ bi ^ ci;
      carry_bit = (ai & bi) | (ci & (ai ^ bi));
      return {carry_bit, sum_bit};
   endfunction

   logic             sub_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   carry_s;
   logic [WIDTH:0]   s_d;
   logic [WIDTH:0]   s_q;
   logic             valid_d;
   logic             valid_q;

`ifdef FOUR_BIT_ADDER_SUB_EN
   assign sub_s = sub;
`else
   assign sub_s = 1'b0;
`endif

   // Ripple chain: carry_s[i] feeds cell i; sub inverts b and seeds the chain.
   always_comb begin
      logic [1:0] cell_s;
      sum_s      = '0;
      carry_s    = '0;
      carry_s[0] = sub_s;
      cell_s     = 2'b00;
      for (int i = 0; i < WIDTH; i++) begin
         cell_s         = full_add(a[i], b[i] ^ sub_s, carry_s[i]);
         sum_s[i]       = cell_s[0];
         carry_s[i+1]   = cell_s[1];
      end
      sum_s[WIDTH] = carry_s[WIDTH];
   end

   // Next-state: reset wins, otherwise capture on in_valid or hold.
   always_comb begin
      s_d     = s_q;
      valid_d = 1'b0;
      if (!rst_n) begin
         s_d     = '0;
         valid_d = 1'b0;
      end else if (in_valid) begin
         s_d     = sum_s;
         valid_d = 1'b1;
      end else begin
         s_d     = s_q;
         valid_d = 1'b0;
      end
   end

   // Result and valid registers.
   always_ff @(posedge clk) begin
      s_q     <= s_d;
      valid_q <= valid_d;
   end

   assign s         = s_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_four_bit_adder.sv
// Directed self-checking bench for four_bit_adder: reset, exhaustive sweep,
// boundaries, hold, mid-stream reset and (with FOUR_BIT_ADDER_SUB_EN) subtract.
module tb_four_bit_adder;

   logic       clk;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       in_valid;
   logic [4:0] s;
   logic       out_valid;
`ifdef FOUR_BIT_ADDER_SUB_EN
   logic       sub;
`endif

   int checks;
   int errors;

   four_bit_adder #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
`ifdef FOUR_BIT_ADDER_SUB_EN
      .sub       (sub),
`endif
      .in_valid  (in_valid),
      .s         (s),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [4:0] exp_sum;
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = 4'hF;
      b        = 4'hF;
`ifdef FOUR_BIT_ADDER_SUB_EN
      sub      = 1'b0;
`endif

      // Reset held two cycles with live operands
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("reset_s", s, 5'h00);
         chk("reset_valid", {4'h0, out_valid}, 5'h00);
      end
      rst_n = 1'b1;

      // Exhaustive sweep, in_valid high every cycle
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            a        = 4'(ia);
            b        = 4'(ib);
            in_valid = 1'b1;
            exp_sum  = 5'(ia + ib);
            tick();
            chk("sweep_s", s, exp_sum);
            chk("sweep_valid", {4'h0, out_valid}, 5'h01);
         end
      end

      // Boundaries
      a = 4'hF; b = 4'h1; tick(); chk("f_plus_1", s, 5'h10);
      a = 4'h8; b = 4'h8; tick(); chk("8_plus_8", s, 5'h10);
      a = 4'hF; b = 4'hF; tick(); chk("f_plus_f", s, 5'h1E);
      a = 4'h0; b = 4'h0; tick(); chk("0_plus_0", s, 5'h00);

      // Hold rule
      a = 4'h3; b = 4'h4; in_valid = 1'b1; tick();
      chk("hold_load_s", s, 5'h07);
      chk("hold_load_valid", {4'h0, out_valid}, 5'h01);
      in_valid = 1'b0; a = 4'h9; b = 4'h9;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_s", s, 5'h07);
         chk("hold_valid", {4'h0, out_valid}, 5'h00);
      end
      a = 4'bxxxx; b = 4'bxxxx; tick();
      chk("hold_x_s", s, 5'h07);

      // Mid-stream reset
      a = 4'h1; b = 4'h2; in_valid = 1'b1; tick();
      chk("stream1_s", s, 5'h03);
      a = 4'h6; b = 4'h7; rst_n = 1'b0; tick();
      chk("midrst_s", s, 5'h00);
      chk("midrst_valid", {4'h0, out_valid}, 5'h00);
      rst_n = 1'b1; a = 4'h2; b = 4'h2; tick();
      chk("post_rst_s", s, 5'h04);
      chk("post_rst_valid", {4'h0, out_valid}, 5'h01);

`ifdef FOUR_BIT_ADDER_SUB_EN
      // Subtract mode
      sub = 1'b1;
      a = 4'h5; b = 4'h3; tick(); chk("sub_5_3", s, 5'h12);
      a = 4'h3; b = 4'h5; tick(); chk("sub_3_5", s, 5'h0E);
      a = 4'h7; b = 4'h7; tick(); chk("sub_7_7", s, 5'h10);
      sub = 1'b0;
      a = 4'h5; b = 4'h3; tick(); chk("add_after_sub", s, 5'h08);
`endif

      in_valid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
